wb_sram_port0_bridge: RTL
=========================

Name: wb_sram_port0_bridge

Overview:
Wishbone classic slave that translates Caravel user-bus cycles onto the 1RW port (port 0) of the 32x256 OpenRAM macro. It registers all macro inputs and captures read data, and sits directly upstream of the macro's port 0. The top level drives the macro's clk0 from wb_clk_i, with no inversion. Saturating read/write counters are exported for test visibility.

Parameters:
BASE_ADDR, 32'h3000_0000, byte base address of the SRAM window.
ADDR_WIDTH, 8, macro word-address width (window = 4*2^ADDR_WIDTH bytes).
DATA_WIDTH, 32, data width.
NUM_WMASKS, 4, byte-lane write-mask width.
COUNT_W, 16, width of the access counters.

Ports:
wb_clk_i  in  1  single clock; all logic on its rising edge
wb_rst_i  in  1  reset, synchronous, active-high
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  1 = write
wbs_sel_i  in  NUM_WMASKS  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  DATA_WIDTH  write data
wbs_ack_o  out  1  single-cycle acknowledge
wbs_dat_o  out  DATA_WIDTH  read data
sram_csb0  out  1  macro chip select, active low
sram_web0  out  1  macro write enable, active low
sram_wmask0  out  NUM_WMASKS  macro byte mask
sram_addr0  out  ADDR_WIDTH  macro word address
sram_din0  out  DATA_WIDTH  macro write data
sram_dout0  in  DATA_WIDTH  macro read data
busy_o  out  1  FSM not in IDLE
rd_count_o  out  COUNT_W  completed reads, saturating
wr_count_o  out  COUNT_W  completed writes, saturating

Behaviour:
- Reset values:
  - sram_csb0=1, sram_web0=1; sram_wmask0, sram_addr0 and sram_din0 are 0.
  - wbs_ack_o=0, wbs_dat_o=0, busy_o=0, both counters 0, state IDLE.
- Hit: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
- Word address = wbs_adr_i[ADDR_WIDTH+1:2]; bits [1:0] are ignored.
- A miss is ignored: no ack, no macro activity.
- FSM states: IDLE, WR, RD, ACK.
- IDLE + hit (edge T0):
  - Register sram_csb0=0, sram_addr0=word address, sram_web0=~wbs_we_i.
  - For writes also register sram_din0=wbs_dat_i and sram_wmask0=wbs_sel_i.
  - For reads register sram_wmask0=0.
  - Next state is WR (write) or RD (read).
- WR (edge T1, macro samples the request here):
  - Register sram_csb0=1, sram_web0=1, wbs_ack_o=1; go to ACK.
  - The write commits on the negedge inside the ack cycle.
  - Write latency: master samples ack at T2.
- RD (edge T1):
  - Register sram_csb0=1, sram_web0=1; go to ACK_PREP (sub-step of RD).
  - At edge T2, register wbs_dat_o=sram_dout0 and wbs_ack_o=1; go to ACK.
  - Read latency: master samples ack at T3.
  - sram_dout0 is sampled only at T2; it is valid there because the macro updates it after the negedge plus its internal delay.
- ACK: wbs_ack_o is high for exactly one cycle; the next edge clears it and returns to IDLE.
  - A new hit is not accepted on the edge that leaves ACK.
  - Minimum request spacing: 3 cycles for writes, 4 for reads.
- Counters: increment on the edge that asserts wbs_ack_o (rd_count_o for reads, wr_count_o for writes); saturate at all-ones, never wrap.
- wbs_dat_o holds the last read data; writes leave it unchanged.
- Write with wbs_sel_i=0: full handshake and ack, memory unchanged, wr_count_o increments.
- wbs_cyc_i deasserted in WR/RD:
  - FSM returns to IDLE, sram_csb0=1, no ack, counter unchanged.
  - A write already sampled by the macro still commits.
- wb_rst_i mid-operation: all outputs return to reset values on that edge. The macro is not reset, so a request it has already sampled still completes.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Package wb_sram_pkg holds:
  - State enum (IDLE, WR, RD, RD2, ACK).
  - Window-compare helper constants (ADDR_LSB = 2, TAG_LSB = ADDR_WIDTH+2).
  - Default BASE_ADDR.
- One sub-module, sat_counter (width parameter, inc, sync reset), instanced twice for the counters.
- Everything else stays in the single FSM module.

Test Plan:
- Write adr=0x3000_0010, dat=0xDEADBEEF, sel=0xF, then read the same address -> first ack 2 cycles after stb sampling, second ack 3 cycles after; wbs_dat_o=0xDEADBEEF; wr_count_o=1, rd_count_o=1.
- Write 0x11223344 to word 5 with sel=0xF, then write 0xAABBCCDD with sel=0x5, then read -> 0x11BB33DD.
- Access adr=0x3000_0400 (outside window) -> no ack for 10 cycles, sram_csb0 stays 1, counters unchanged.
- Read issued, wbs_cyc_i dropped the cycle after acceptance -> no ack, FSM in IDLE next edge, rd_count_o unchanged.
- wb_rst_i asserted while in RD -> next edge: ack=0, csb0=1, wbs_dat_o=0, busy_o=0, counters 0. A subsequent read works normally.
- With COUNT_W=2, issue 5 writes -> wr_count_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-OpenRAM port 0 bridge.
package wb_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD2,
    ACK
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h3000_0000;
  localparam int          ADDR_LSB           = 2;
  localparam int          DEFAULT_ADDR_WIDTH = 8;
  localparam int          TAG_LSB            = DEFAULT_ADDR_WIDTH + ADDR_LSB;

  // Lowest byte-address bit that takes part in the window compare.
  function automatic int tag_lsb(input int addr_width);
    return addr_width + ADDR_LSB;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/wb_sram_port0_bridge.sv
// Wishbone classic slave driving the 1RW port of a 32x256 OpenRAM macro.
// All macro inputs are registered; the macro's clk0 is wb_clk_i, uninverted.
module wb_sram_port0_bridge
  import wb_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4,
  parameter int          COUNT_W    = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  busy_o,
  output logic [COUNT_W-1:0]    rd_count_o,
  output logic [COUNT_W-1:0]    wr_count_o
);

  localparam int TAG_LSB_W = tag_lsb(ADDR_WIDTH);

  state_t                state_reg, state_next;
  logic                  csb_reg, csb_next;
  logic                  web_reg, web_next;
  logic [NUM_WMASKS-1:0] wmask_reg, wmask_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] din_reg, din_next;
  logic                  ack_reg, ack_next;
  logic [DATA_WIDTH-1:0] dat_reg, dat_next;
  logic                  busy_reg;
  logic                  rd_inc, wr_inc;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  unused_adr_bits;

  assign hit = wbs_cyc_i && wbs_stb_i &&
               (wbs_adr_i[31:TAG_LSB_W] == BASE_ADDR[31:TAG_LSB_W]);
  assign word_addr       = wbs_adr_i[TAG_LSB_W-1:ADDR_LSB];
  assign unused_adr_bits = ^wbs_adr_i[ADDR_LSB-1:0];

  always_comb begin
    state_next = state_reg;
    csb_next   = csb_reg;
    web_next   = web_reg;
    wmask_next = wmask_reg;
    addr_next  = addr_reg;
    din_next   = din_reg;
    ack_next   = 1'b0;
    dat_next   = dat_reg;
    rd_inc     = 1'b0;
    wr_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          csb_next  = 1'b0;
          web_next  = ~wbs_we_i;
          addr_next = word_addr;
          if (wbs_we_i) begin
            din_next   = wbs_dat_i;
            wmask_next = wbs_sel_i;
            state_next = WR;
          end else begin
            wmask_next = '0;
            state_next = RD;
          end
        end
      end
      // The macro latches the request on this edge, so deselect it regardless.
      WR: begin
        csb_next = 1'b1;
        web_next = 1'b1;
        if (wbs_cyc_i) begin
          ack_next   = 1'b1;
          wr_inc     = 1'b1;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        csb_next   = 1'b1;
        web_next   = 1'b1;
        state_next = wbs_cyc_i ? RD2 : IDLE;
      end
      // dout0 settles after the negedge, so it is only safe to capture here.
      RD2: begin
        if (wbs_cyc_i) begin
          dat_next   = sram_dout0;
          ack_next   = 1'b1;
          rd_inc     = 1'b1;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      csb_reg   <= 1'b1;
      web_reg   <= 1'b1;
      wmask_reg <= '0;
      addr_reg  <= '0;
      din_reg   <= '0;
      ack_reg   <= 1'b0;
      dat_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      csb_reg   <= csb_next;
      web_reg   <= web_next;
      wmask_reg <= wmask_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      ack_reg   <= ack_next;
      dat_reg   <= dat_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  sat_counter #(.WIDTH(COUNT_W)) u_rd_count (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .inc   (rd_inc),
    .count (rd_count_o)
  );

  sat_counter #(.WIDTH(COUNT_W)) u_wr_count (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .inc   (wr_inc),
    .count (wr_count_o)
  );

  assign wbs_ack_o   = ack_reg;
  assign wbs_dat_o   = dat_reg;
  assign sram_csb0   = csb_reg;
  assign sram_web0   = web_reg;
  assign sram_wmask0 = wmask_reg;
  assign sram_addr0  = addr_reg;
  assign sram_din0   = din_reg;
  assign busy_o      = busy_reg;

endmodule
